// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder for the MEM stage of the lab pipeline. It accepts one
// load or store at a time, holds it for a fixed number of BUSY cycles, then
// touches the backing store on the BUSY-to-RESP edge and presents a
// one-cycle response. While a request is outstanding, Stall freezes the
// pipeline.
//
// Parameters
//   DEPTH    number of 32-bit words in the backing store (power of two, 4..1024)
//   LATENCY  number of BUSY cycles per request (1..15)
//
// Ports
//   Clk           single clock, rising edge
//   Reset         synchronous, active-high reset (memory contents survive it)
//   Req_Valid     request present
//   Req_Ready     responder idle and able to accept
//   Req_Write     1 = store, 0 = load
//   Req_Size      00 word, 01 half, 10 byte, 11 illegal
//   Req_Unsigned  1 = zero-extend loads, 0 = sign-extend
//   Req_Address   byte address
//   Req_WData     store data, right-aligned
//   Resp_Valid    one-cycle completion pulse
//   Resp_RData    load result, right-aligned and extended, held between responses
//   Resp_Err      request was rejected (only meaningful with Resp_Valid)
//   Stall         a request is outstanding
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Unsigned,
  input  logic [31:0] Req_Address,
  input  logic [31:0] Req_WData,
  output logic        Resp_Valid,
  output logic [31:0] Resp_RData,
  output logic        Resp_Err,
  output logic        Stall
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0]    count;
  logic          accept;
  logic          commit;

  // Captured request
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;

  // Decoded request
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [3:0]    byte_en;
  logic [31:0]   store_data;

  // Read path
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_data;

  // Response registers
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic [31:0]   mem [DEPTH];

  // A request is taken whenever we are idle and one is offered; the reset
  // priority in the registers below keeps a request offered during Reset
  // from being accepted.
  assign accept = (state == IDLE) && Req_Valid;

  // The memory access happens on the edge that leaves the last BUSY cycle.
  assign commit = (state == BUSY) && (count == 4'd0);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESP when the counter
  // has run out, RESP always lasts a single cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = BUSY;
      BUSY:    if (count == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latency counter: loaded with LATENCY-1 on accept so that BUSY lasts
  // exactly LATENCY cycles, then counts down to zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= 4'd0;
    end else if (accept) begin
      count <= COUNT_LOAD;
    end else if ((state == BUSY) && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  // Request capture. Only the accept edge loads these, so the request ports
  // are free to change while the block is busy.
  always_ff @(posedge Clk) begin
    if (!Reset && accept) begin
      req_write    <= Req_Write;
      req_size     <= Req_Size;
      req_unsigned <= Req_Unsigned;
      req_addr     <= Req_Address;
      req_wdata    <= Req_WData;
    end
  end

  // Address decode, error detection and store lane selection. The range
  // check looks at the address bits above the word index so that an
  // out-of-range address can never alias onto a real word.
  always_comb begin
    lane       = req_addr[1:0];
    word_idx   = req_addr[AW+1:2];
    req_err    = (req_size == 2'b11)
              || ((req_size == SIZE_HALF) && req_addr[0])
              || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
              || (|req_addr[31:AW+2]);
    byte_en    = 4'b0000;
    store_data = req_wdata;
    case (req_size)
      SIZE_WORD: begin
        byte_en    = 4'b1111;
        store_data = req_wdata;
      end
      SIZE_HALF: begin
        byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{req_wdata[15:0]}};
      end
      SIZE_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{req_wdata[7:0]}};
      end
      default: begin
        byte_en    = 4'b0000;
        store_data = req_wdata;
      end
    endcase
  end

  // Backing store write port. Replicating the store data across lanes lets
  // the byte enables alone pick which lanes change. A Reset on the commit
  // edge abandons the store.
  always_ff @(posedge Clk) begin
    if (!Reset && commit && req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  // Load alignment: shift the addressed lane down to bit 0, then extend.
  // Word loads are always lane 0 when legal, so the shift is a no-op there.
  always_comb begin
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (req_size)
      SIZE_HALF: load_data = {{16{rd_shift[15] & ~req_unsigned}}, rd_shift[15:0]};
      SIZE_BYTE: load_data = {{24{rd_shift[7] & ~req_unsigned}}, rd_shift[7:0]};
      default:   load_data = rd_shift;
    endcase
  end

  // Response data and error flag are captured on the commit edge and the
  // data is held until the next response. Stores and rejected requests
  // return zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else if (commit) begin
      resp_err_q   <= req_err;
      resp_rdata_q <= (req_err || req_write) ? 32'd0 : load_data;
    end
  end

  // Outputs are decoded from the state so they can never disagree with it;
  // Resp_Err is masked outside RESP.
  always_comb begin
    Req_Ready  = (state == IDLE);
    Stall      = (state != IDLE);
    Resp_Valid = (state == RESP);
    Resp_Err   = (state == RESP) && resp_err_q;
    Resp_RData = resp_rdata_q;
  end

endmodule
